cla_16x16: RTL and testbench
============================

// Module: cla_16x16
// PURPOSE
//   16-bit carry-lookahead adder producing a 17-bit sum (carry-out in the MSB).
//   Built from four 4-bit CLA slices (submodule cla_4x4, in this file), each
//   exporting group generate/propagate to a second-level lookahead unit.
//   Arithmetic building block for the multiplier datapaths.
//   Adds one output register stage so the block sits on a clocked pipeline.
// PARAMETERS
//   none -- operand width fixed at 16, lookahead group size fixed at 4.
// PORTS
//   clk    in   1   clock; all state updates on the rising edge
//   rst_n  in   1   reset, asynchronous, active-low
//   a      in   16  operand A, unsigned
//   b      in   16  operand B, unsigned
//   cin    in   1   carry-in (tie to 1'b0 for plain addition)
//   sum    out  17  registered a + b + cin; sum[16] = carry-out
// BEHAVIOUR
//   - Single clock domain; reset is asynchronous and active-low.
//   - Reset: while rst_n = 0, sum = 17'h0, with no clock required.
//     Deassertion takes effect at the next rising clk.
//   - Reset asserted mid-operation clears sum immediately.
//   - Latency: 1 cycle. On each rising clk with rst_n = 1, sum <= a + b + cin.
//   - Throughput: one result per cycle. No handshake, no valid or stall.
//     Inputs are sampled every edge.
//   - Arithmetic: unsigned, exact, no overflow. Max 16'hFFFF + 16'hFFFF + 1 =
//     17'h1FFFF. Result is zero-extended into 17 bits.
//   - cla_4x4 slice (combinational): inputs a[3:0], b[3:0], ci.
//     Outputs s[3:0], co, group G, group P.
//     - Per bit: g_i = a_i & b_i, p_i = a_i ^ b_i.
//     - Carries: c1 = g0 | p0&ci, c2 = g1 | p1&g0 | p1&p0&ci, and so on up to c4.
//       Each carry is a flat sum-of-products; no ripple chain.
//     - s_i = p_i ^ c_i.
//     - G = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0; P = p3&p2&p1&p0.
//     - co equals c4 = G | P&ci.
//     - The standalone slice sum {co, s} must equal a + b + ci for all 512
//       input combinations.
//   - Second level: group carries C4, C8, C12, C16 are computed from the slice
//     G/P and cin with the same lookahead equations. They feed the slice ci
//     inputs of slices 1..3; C16 is sum[16].
//   - The combinational path from a/b/cin to the register D input must not
//     contain a 16-stage ripple chain. Behavioural "+" is not permitted in
//     the core; it is allowed only in the bench.
//   - No X propagation from the register after reset.
// TESTING
//   1. rst_n = 0 with a = 16'hFFFF, b = 16'h0001 applied
//      -> sum = 0 with no clock edge; rst_n = 1, one edge -> sum = 17'h10000.
//   2. Exhaustive cla_4x4: all a, b in 0..15 with ci = 0 and ci = 1
//      -> {co, s} = a + b + ci; e.g. 15 + 15 + 0 = 5'b11110.
//   3. Carry across all groups: a = 16'hFFFF, b = 16'h0000, cin = 1
//      -> sum = 17'h10000 one cycle later.
//      a = 16'h0FFF, b = 16'h0001 -> 17'h01000.
//   4. Max operands: a = b = 16'hFFFF, cin = 1 -> sum = 17'h1FFFF.
//      a = b = 0, cin = 0 -> 17'h0.
//   5. 10000 random a, b with cin = 0, a new pair every clock
//      -> each sum equals the previous cycle's a + b (17-bit compare).
//   6. Assert rst_n mid-stream between edges -> sum drops to 0 at once.
//      The first edge after release resumes correct results.

Source files
------------

// File: rtl/cla_16x16_if.sv
// Operand/result bundle for the 16-bit carry-lookahead adder.
// There is no handshake on this bus: a, b and cin are sampled on every
// rising clock edge and sum always holds the result of the previous edge.
interface cla_16x16_if;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [16:0] sum;

  // Drives the operands and observes the registered sum.
  modport master (
    output a,
    output b,
    output cin,
    input  sum
  );

  // The adder itself: consumes operands and produces the sum.
  modport slave (
    input  a,
    input  b,
    input  cin,
    output sum
  );
endinterface

// File: rtl/cla_16x16.sv
// 16-bit two-level carry-lookahead adder with one output register stage.
// Four 4-bit lookahead slices export group generate/propagate to a second
// lookahead level, which produces the inter-slice carries C4..C16 directly
// from cin. No ripple chain exists anywhere between the operands and the
// register D input.

// 4-bit carry-lookahead slice. Every carry is a flat sum of products.
module cla_4x4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co,
  output logic       gg,
  output logic       gp
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Per-bit generate/propagate, lookahead carries, sum bits, group G/P.
  always_comb begin
    g = a & b;
    p = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]);
    gp   = p[3] & p[2] & p[1] & p[0];
    c[4] = gg | (gp & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end
endmodule

// Top level: four slices, second-level lookahead, output register.
module cla_16x16 (
  input  logic         clk,
  input  logic         rst_n,
  cla_16x16_if.slave   bus
);
  logic [3:0]  grp_g;
  logic [3:0]  grp_p;
  logic [4:0]  grp_c;
  logic [15:0] s_comb;
  logic [16:0] sum_q;
  // Slice carry-outs duplicate the second-level carries; kept only for
  // debug visibility, the second level is the authoritative source.
  logic [3:0]  unused_co;

  // Second-level lookahead: group carries from slice G/P and cin.
  always_comb begin
    grp_c[0] = bus.cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & bus.cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0])
             | (grp_p[1] & grp_p[0] & bus.cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1])
             | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & bus.cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2])
             | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & bus.cin);
  end

  for (genvar k = 0; k < 4; k++) begin : g_slice
    cla_4x4 u_slice (
      .a  (bus.a[4*k +: 4]),
      .b  (bus.b[4*k +: 4]),
      .ci (grp_c[k]),
      .s  (s_comb[4*k +: 4]),
      .co (unused_co[k]),
      .gg (grp_g[k]),
      .gp (grp_p[k])
    );
  end

  // Output register: cleared asynchronously, otherwise captures the sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 17'h0;
    end else begin
      sum_q <= {grp_c[4], s_comb};
    end
  end

  assign bus.sum = sum_q;
endmodule

// File: tb/tb_cla_16x16.sv
// Directed and random checks for cla_16x16 and its cla_4x4 slice.
module tb_cla_16x16;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  cla_16x16_if bus ();

  cla_16x16 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Standalone slice for the exhaustive 4-bit check.
  logic [3:0] sl_a, sl_b, sl_s;
  logic       sl_ci, sl_co, sl_g, sl_p;

  cla_4x4 u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (sl_ci),
    .s  (sl_s),
    .co (sl_co),
    .gg (sl_g),
    .gp (sl_p)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;

  vec_t vecs[10];
  logic [16:0] exp_q[$];

  // Clock: 10 ns period, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [16:0] act,
                       input logic [16:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b,
                       input logic cin);
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
  endtask

  initial begin
    logic [15:0] ra, rb;
    logic [16:0] e;
    n_checks = 0;
    n_pass   = 0;

    vecs[0] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
    vecs[1] = '{16'h0FFF, 16'h0001, 1'b0, 17'h01000};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 17'h05555};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    vecs[6] = '{16'hAAAA, 16'h5555, 1'b1, 17'h10000};
    vecs[7] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
    vecs[8] = '{16'h00FF, 16'h0001, 1'b0, 17'h00100};
    vecs[9] = '{16'h7FFF, 16'h0000, 1'b1, 17'h08000};

    // Reset asserted with operands applied, before any clock edge.
    rst_n = 1'b0;
    drive(16'hFFFF, 16'h0001, 1'b0);
    #3;
    check("reset_no_clock", bus.sum, 17'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_after_reset", bus.sum, 17'h10000);

    // Exhaustive slice check.
    for (int ci = 0; ci < 2; ci++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          sl_a  = 4'(x);
          sl_b  = 4'(y);
          sl_ci = 1'(ci);
          #1;
          check("slice_sum", {12'h0, sl_co, sl_s}, 17'(x + y + ci));
        end
      end
    end

    // Directed table, one vector per cycle, checked one edge later.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].a, vecs[i].b, vecs[i].cin);
      @(negedge clk);
      check($sformatf("vec%0d", i), bus.sum, vecs[i].exp);
    end

    // Back-to-back random stream: each result lands one edge later.
    @(negedge clk);
    exp_q.delete();
    for (int i = 0; i <= 10000; i++) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("random_stream", bus.sum, e);
      end
      if (i < 10000) begin
        ra = 16'($urandom_range(0, 16'hFFFF));
        rb = 16'($urandom_range(0, 16'hFFFF));
        drive(ra, rb, 1'b0);
        exp_q.push_back({1'b0, ra} + {1'b0, rb});
      end
      @(negedge clk);
    end

    // Reset mid-stream between edges.
    drive(16'h0001, 16'h0002, 1'b0);
    @(negedge clk);
    check("pre_mid_reset", bus.sum, 17'h00003);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_clear", bus.sum, 17'h0);
    @(negedge clk);
    check("mid_reset_hold", bus.sum, 17'h0);
    rst_n = 1'b1;
    drive(16'h00F0, 16'h0010, 1'b0);
    @(negedge clk);
    check("resume_after_reset", bus.sum, 17'h00100);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
